nibble_serial_add_ctrl: RTL and testbench

Sequencing controller that performs WIDTH-bit add/subtract by time-multiplexing one ripple_add_4bit_structural instance, one nibble per clock, LSB nibble first. It latches operands on a start handshake, steps the carry through a register between nibbles, and reports the result with a one-cycle done pulse. It is used where a full-width adder costs too much area and a few cycles of latency are acceptable.

---
 rtl/nibble_serial_add_ctrl.sv | 147 ++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit add/subtract controller. It reuses one 4-bit ripple adder
// for one nibble per clock, LSB nibble first, and pulses done when the result is ready.

module ripple_add_4bit_structural (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c_s;

  assign c_s[0] = cin;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c_s[i];
      assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = c_s[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state_r, state_s;
  logic [IDXW-1:0]   idx_r;
  logic [WIDTH-1:0]  a_r, b_r, sum_r;
  logic              carry_r, carry_out_r, overflow_r;
  logic [3:0]        add_sum_s;
  logic              add_cout_s;
  logic              last_s;

  // b_r already holds ~b in subtract mode, so the adder always adds.
  ripple_add_4bit_structural u_add (
    .a    (a_r[{idx_r, 2'b00} +: 4]),
    .b    (b_r[{idx_r, 2'b00} +: 4]),
    .cin  (carry_r),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  assign last_s = (idx_r == IDXW'(NIB - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, nibble stepping and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= {IDXW{1'b0}};
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= op_sub ? ~b : b;
            carry_r <= op_sub ? 1'b1 : carry_in;
            idx_r   <= {IDXW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          sum_r[{idx_r, 2'b00} +: 4] <= add_sum_s;
          carry_r                    <= add_cout_s;
          if (last_s) begin
            carry_out_r <= add_cout_s;
            // Top nibble's MSB is the new sign bit of the result.
            overflow_r  <= (a_r[WIDTH-1] ~^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ add_sum_s[3]);
          end else begin
            idx_r <= idx_r + IDXW'(1'b1);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state_r == RUN);
  assign done      = (state_r == DONE);
  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized scoreboard bench for nibble_serial_add_ctrl: a handshake model
// queues arithmetic expectations, and a monitor checks them on every done pulse.

module tb_nibble_serial_add_ctrl;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   mcnt;
  bit   prev_done = 1'b0;
  exp_t exp_q[$];

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Arithmetic reference using plain signed/unsigned integers.
  function automatic exp_t ref_op(input logic sub, input logic [W-1:0] av,
                                  input logic [W-1:0] bv, input logic cin);
    exp_t   e;
    longint ua, ub, sa, sb, r, sr, lim;
    ua  = longint'(av);
    ub  = longint'(bv);
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    lim = longint'(1) << (W - 1);
    if (sub) begin
      r    = ua - ub;
      sr   = sa - sb;
      e.co = (ua >= ub);
    end else begin
      r    = ua + ub + longint'(cin);
      sr   = sa + sb + longint'(cin);
      e.co = (r >= (lim << 1));
    end
    e.s  = r[W-1:0];
    e.ov = (sr > lim - 1) || (sr < -lim);
    return e;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (ok) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake model: idle until start, busy for NIB cycles, done for one, then idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0;
      exp_q.delete();
    end else if (mcnt == 0) begin
      if (start) begin
        mcnt <= 1;
        exp_q.push_back(ref_op(op_sub, a, b, carry_in));
      end
    end else if (mcnt == NIB + 1) begin
      mcnt <= 0;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  // Monitor: reset values, per-cycle handshake and popped results.
  always begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
      chk(done == 1'b0, "rst_done", 64'(done), 64'd0);
      chk(sum == '0, "rst_sum", 64'(sum), 64'd0);
      chk(carry_out == 1'b0, "rst_carry_out", 64'(carry_out), 64'd0);
      chk(overflow == 1'b0, "rst_overflow", 64'(overflow), 64'd0);
      prev_done = 1'b0;
    end else begin
      chk({busy, done} == {(mcnt >= 1 && mcnt <= NIB), (mcnt == NIB + 1)},
          "handshake", 64'({busy, done}),
          64'({(mcnt >= 1 && mcnt <= NIB), (mcnt == NIB + 1)}));
      if (done) begin
        chk(!prev_done, "done_single_cycle", 64'(prev_done), 64'd0);
        if (exp_q.size() == 0) begin
          chk(1'b0, "result_unexpected", 64'(sum), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({sum, carry_out, overflow} == {e.s, e.co, e.ov}, "result",
              64'({sum, carry_out, overflow}), 64'({e.s, e.co, e.ov}));
        end
      end
      prev_done = done;
    end
  end

  // Issue one start pulse; optionally keep start high with junk while it runs.
  task automatic issue(input logic sub, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cin, input bit noise);
    start = 1'b1; op_sub = sub; a = av; b = bv; carry_in = cin;
    @(posedge clk); #1;
    start = noise; op_sub = 1'($urandom); a = W'($urandom); b = W'($urandom);
    carry_in = 1'($urandom);
    repeat (NIB + 1) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'h0000;
      1:       v = 16'hFFFF;
      2:       v = 16'h8000;
      3:       v = 16'h7FFF;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    rst_n = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue(1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b0);
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    issue(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0);
    issue(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b0);
    issue(1'b0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b1);

    // start held high with changing operands
    start = 1'b1;
    repeat (24) begin
      op_sub = 1'($urandom); a = pick(); b = pick(); carry_in = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (NIB + 3) begin
      @(posedge clk); #1;
    end

    // abort an add part way through
    start = 1'b1; op_sub = 1'b0; a = 16'h1234; b = 16'h4321; carry_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), pick(), pick(), 1'($urandom), 1'($urandom));
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
